fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction fetch unit. It is the producer side of the 16-bit instruction bus that feeds decode.
- Holds the CHIP-8 program counter and the call stack. Reads each instruction as two bytes, big-endian, from byte-wide program memory.
- Presents the instruction with a valid/ready handshake.
- Takes next-PC commands (jump, call, return, skip) from the execute stage when each instruction is consumed.

Parameters:
- RESET_PC, 12'h200, PC value after reset (CHIP-8 program start).
- STACK_DEPTH, 16, number of return-address entries.
- SP_W, 5, stack pointer width; must hold 0..STACK_DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mem_addr  out  12  program memory byte address
- mem_rd  out  1  one-cycle read strobe
- mem_data  in  8  read data; sampled only when mem_valid=1 in a WAIT state
- mem_valid  in  1  read data valid; arrives one or more cycles after mem_rd
- instr_out  out  16  fetched instruction, high byte at PC, low byte at PC+1
- instr_valid  out  1  instr_out holds a complete instruction
- instr_ready  in  1  consumer accepts instr_out
- cmd_jump  in  1  next PC = cmd_addr
- cmd_call  in  1  push PC+2, next PC = cmd_addr
- cmd_ret  in  1  next PC = popped address
- cmd_skip  in  1  next PC = PC+4
- cmd_addr  in  12  jump/call target
- pc  out  12  address of the current instruction
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, active-high): pc=RESET_PC, sp=0, state=FETCH_HI, mem_rd=0, mem_addr=0, instr_out=0, instr_valid=0, stack_err=0. Stack contents are not reset.
- FSM states: FETCH_HI, WAIT_HI, FETCH_LO, WAIT_LO, HOLD.
  - FETCH_HI: mem_rd=1, mem_addr=pc for exactly one cycle, then WAIT_HI.
  - WAIT_HI: hold until mem_valid=1; latch mem_data into instr_out[15:8]; go to FETCH_LO.
  - FETCH_LO: mem_rd=1, mem_addr=pc+1 (mod 4096), then WAIT_LO.
  - WAIT_LO: on mem_valid=1, latch instr_out[7:0]; go to HOLD.
  - HOLD: instr_valid=1. instr_out and pc are stable until consumed.
- Consume event: state HOLD and instr_ready=1. On that edge instr_valid drops, pc updates, and state returns to FETCH_HI.
- mem_valid outside WAIT_HI/WAIT_LO is ignored. mem_rd is 0 in every state other than FETCH_HI and FETCH_LO.
- Next-PC priority on consume: ret > call > jump > skip > default (pc+2). Lower-priority commands asserted in the same cycle are ignored.
- cmd_* inputs outside a consume event are ignored.
- All PC arithmetic is 12-bit and wraps mod 4096: 12'hFFE+2 = 12'h000; skip from 12'hFFE gives 12'h002.
- Odd PC values are legal.
- Call:
  - sp<STACK_DEPTH: stack[sp]=pc+2, sp=sp+1, pc=cmd_addr.
  - sp==STACK_DEPTH: no push, sp unchanged, stack_err=1, pc=cmd_addr (jump still taken).
- Ret:
  - sp>0: sp=sp-1, pc=stack[sp-1].
  - sp==0: stack_err=1, pc=pc+2.
- stack_err is cleared only by rst.
- Latency with 1-cycle memory: consume at cycle C gives instr_valid=1 at C+5. Reset release gives instr_valid=1 at the 5th rising edge.
- instr_ready asserted before HOLD has no effect.
- Reset asserted mid-fetch abandons the fetch immediately; no partial instruction is presented.

Decomposition:
- Shared chip8_pkg holds:
  - RESET_PC default (12'h200)
  - PC/address width 12
  - FSM state encodings FETCH_HI..HOLD
- Sub-module chip8_call_stack: STACK_DEPTH x 12-bit LIFO.
  - Ports: push, pop, push_data, top_data, sp, full, empty.
  - Asynchronous active-high rst clears sp.
  - fetch owns all priority and error logic.

Test Plan:
- Reset, memory holding 0x12,0x34 at 0x200/0x201, instr_ready=1 -> instr_out=16'h1234, instr_valid=1 at edge 5; mem_addr sequence 0x200, 0x201; next fetch from 0x202.
- In HOLD, instr_ready=0 for 10 cycles -> instr_out, pc, instr_valid stable, no mem_rd pulses.
- Consume with cmd_call=1, cmd_addr=0x300 at pc=0x204, then consume at 0x300 with cmd_ret=1 -> pc 0x300, then 0x206; sp returns to 0.
- 16 nested calls, then a 17th -> stack_err=1, pc=cmd_addr, sp=16. Separately, ret with sp=0 from reset -> stack_err=1, pc=0x202.
- Consume with cmd_ret, cmd_call and cmd_skip all asserted and sp=1 holding 0x250 -> pc=0x250, no push. Skip at pc=0xFFE -> pc=0x002.
- Memory with random 1-4 cycle mem_valid delay plus spurious mem_valid in FETCH states -> correct instr_out each time; rst pulse during WAIT_LO -> instr_valid=0, refetch from 0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg -- shared definitions for the CHIP-8 front end.
//   PC_W             : program counter / program memory address width
//   RESET_PC_DEFAULT : address of the first instruction after reset
//   fetch_state_t    : instruction fetch FSM states
package chip8_pkg;

  localparam int PC_W = 12;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 12'h200;

  typedef enum logic [2:0] {
    FETCH_HI = 3'd0,
    WAIT_HI  = 3'd1,
    FETCH_LO = 3'd2,
    WAIT_LO  = 3'd3,
    HOLD     = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/chip8_call_stack.sv
// chip8_call_stack -- return-address LIFO for the fetch unit.
//   clk, rst   : clock, asynchronous active-high reset (clears sp only)
//   push       : store push_data at sp and increment sp (ignored when full)
//   pop        : decrement sp (ignored when empty)
//   push_data  : address to store
//   top_data   : most recently pushed address (entry sp-1)
//   sp         : number of valid entries, 0..STACK_DEPTH
//   full/empty : sp == STACK_DEPTH / sp == 0
// Overflow/underflow policy lives in the caller.
module chip8_call_stack
  import chip8_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  entries [STACK_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = sp[IDX_W-1:0];
  // Wraps to the last entry when sp == STACK_DEPTH, which is the top there.
  assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign top_data = entries[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage is deliberately not reset; only sp defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch.sv
// fetch -- CHIP-8 instruction fetch unit.
// Reads two bytes (big-endian) from byte-wide program memory, presents the
// 16-bit instruction to decode with a valid/ready handshake, and applies the
// execute stage's next-PC command when the instruction is consumed.
//   clk, rst        : clock, asynchronous active-high reset
//   mem_addr/mem_rd : program memory byte address and one-cycle read strobe
//   mem_data/valid  : read response, accepted only while waiting for it
//   instr_out/valid : fetched instruction and its valid flag
//   instr_ready     : decode accepts instr_out
//   cmd_ret/call/jump/skip, cmd_addr : next-PC command, priority in that order
//   pc              : address of the current instruction
//   stack_err       : sticky call-stack overflow/underflow flag
module fetch
  import chip8_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              STACK_DEPTH = 16,
  parameter int              SP_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [7:0]      mem_data,
  input  logic            mem_valid,
  output logic [15:0]     instr_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            cmd_jump,
  input  logic            cmd_call,
  input  logic            cmd_ret,
  input  logic            cmd_skip,
  input  logic [PC_W-1:0] cmd_addr,
  output logic [PC_W-1:0] pc,
  output logic            stack_err
);

  fetch_state_t    state;
  logic            consume;
  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] next_pc;
  logic            want_push;
  logic            want_pop;
  logic            set_err;
  logic            pop_ok;

  logic [PC_W-1:0] stk_top;
  logic [SP_W-1:0] stk_sp;
  logic            stk_full;
  logic            stk_empty;

  assign consume  = (state == HOLD) && instr_ready;
  assign pc_plus2 = pc + PC_W'(2);
  assign pop_ok   = !stk_empty && (stk_sp != '0);

  // Next-PC selection: ret > call > jump > skip > sequential.
  always_comb begin
    next_pc   = pc_plus2;
    want_push = 1'b0;
    want_pop  = 1'b0;
    set_err   = 1'b0;
    if (cmd_ret) begin
      if (pop_ok) begin
        want_pop = 1'b1;
        next_pc  = stk_top;
      end else begin
        set_err  = 1'b1;
      end
    end else if (cmd_call) begin
      // The call target is taken even when the return address cannot be saved.
      next_pc = cmd_addr;
      if (stk_full) begin
        set_err   = 1'b1;
      end else begin
        want_push = 1'b1;
      end
    end else if (cmd_jump) begin
      next_pc = cmd_addr;
    end else if (cmd_skip) begin
      next_pc = pc + PC_W'(4);
    end
  end

  chip8_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .SP_W        (SP_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (consume && want_push),
    .pop       (consume && want_pop),
    .push_data (pc_plus2),
    .top_data  (stk_top),
    .sp        (stk_sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_HI;
      pc          <= RESET_PC;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      case (state)
        // Two cycles: the first registers the (possibly just updated) pc onto
        // mem_addr and raises mem_rd, the second drops the strobe.
        FETCH_HI: begin
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end else begin
            mem_rd   <= 1'b0;
            state    <= WAIT_HI;
          end
        end
        // The low-byte request is issued on the same edge the high byte lands,
        // so FETCH_LO already carries the strobe.
        WAIT_HI: begin
          if (mem_valid) begin
            instr_out[15:8] <= mem_data;
            mem_rd          <= 1'b1;
            mem_addr        <= pc + PC_W'(1);
            state           <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          mem_rd <= 1'b0;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          if (mem_valid) begin
            instr_out[7:0] <= mem_data;
            instr_valid    <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            if (set_err) begin
              stack_err <= 1'b1;
            end
            state       <= FETCH_HI;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= FETCH_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch -- self-checking bench for the fetch unit. A byte-wide memory
// responder with optional random latency and spurious mem_valid pulses feeds
// the DUT; a reference model (pc, return-address queue, sticky error) predicts
// each presented instruction.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        cmd_jump, cmd_call, cmd_ret, cmd_skip;
  logic [11:0] cmd_addr;
  logic [11:0] pc;
  logic        stack_err;

  always #5 clk = ~clk;

  fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cmd_jump    (cmd_jump),
    .cmd_call    (cmd_call),
    .cmd_ret     (cmd_ret),
    .cmd_skip    (cmd_skip),
    .cmd_addr    (cmd_addr),
    .pc          (pc),
    .stack_err   (stack_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [7:0]  mem_img [4096];
  logic [11:0] rd_log [$];
  int          max_extra = 0;
  bit          spur_en   = 1'b0;

  initial begin
    bit          pend;
    logic [11:0] pend_addr;
    int          cnt;
    pend = 1'b0;
    pend_addr = '0;
    cnt = 0;
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend = 1'b0;
        mem_valid <= 1'b0;
        mem_data  <= 8'h00;
      end else begin
        mem_valid <= 1'b0;
        mem_data  <= 8'($urandom);
        if (mem_rd) begin
          pend      = 1'b1;
          pend_addr = mem_addr;
          cnt       = $urandom_range(max_extra, 0);
          rd_log.push_back(mem_addr);
        end
        if (pend) begin
          if (cnt == 0) begin
            mem_valid <= 1'b1;
            mem_data  <= mem_img[pend_addr];
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end else if (spur_en && ($urandom_range(1, 0) == 1)) begin
          mem_valid <= 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [11:0] m_pc;
  logic [11:0] m_stack [$];
  bit          m_err;
  bit          junk_en = 1'b0;

  task automatic model_reset();
    m_pc = 12'h200;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  function automatic logic [15:0] exp_instr(input logic [11:0] p);
    logic [11:0] q;
    q = p + 12'd1;
    return {mem_img[p], mem_img[q]};
  endfunction

  task automatic model_consume(input bit r, input bit c, input bit j, input bit s,
                               input logic [11:0] a);
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_err = 1'b1;
        m_pc  = m_pc + 12'd2;
      end
    end else if (c) begin
      if (m_stack.size() < 16) m_stack.push_back(m_pc + 12'd2);
      else m_err = 1'b1;
      m_pc = a;
    end else if (j) begin
      m_pc = a;
    end else if (s) begin
      m_pc = m_pc + 12'd4;
    end else begin
      m_pc = m_pc + 12'd2;
    end
  endtask

  task automatic clear_cmds();
    instr_ready = 1'b0;
    cmd_jump = 1'b0;
    cmd_call = 1'b0;
    cmd_ret  = 1'b0;
    cmd_skip = 1'b0;
    cmd_addr = '0;
  endtask

  // Waits (bounded) for instr_valid, then compares against the model.
  // Stray ready/commands are driven only while not in HOLD when junk_en is set.
  task automatic await_check(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < budget) begin
      if (junk_en) begin
        instr_ready = 1'($urandom);
        cmd_jump = 1'($urandom);
        cmd_call = 1'($urandom);
        cmd_ret  = 1'($urandom);
        cmd_skip = 1'($urandom);
        cmd_addr = 12'($urandom);
      end
      @(negedge clk);
      n++;
    end
    clear_cmds();
    chk({tag, ".valid"}, instr_valid, 1'b1);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".instr"}, instr_out, exp_instr(m_pc));
    chk({tag, ".err"}, stack_err, m_err);
    $display("txn %s: pc=%h instr=%h err=%0d", tag, pc, instr_out, stack_err);
  endtask

  // Called at a negedge with the instruction presented.
  task automatic consume(input bit r, input bit c, input bit j, input bit s,
                         input logic [11:0] a);
    instr_ready = 1'b1;
    cmd_ret = r; cmd_call = c; cmd_jump = j; cmd_skip = s; cmd_addr = a;
    @(posedge clk);
    #1;
    clear_cmds();
    model_consume(r, c, j, s, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rd_log.delete();
    rst = 1'b0;
  endtask

  logic [11:0] saved_pc;
  logic [15:0] saved_instr;

  initial begin
    for (int i = 0; i < 4096; i++) mem_img[i] = 8'($urandom);
    mem_img[12'h200] = 8'h12;
    mem_img[12'h201] = 8'h34;
    clear_cmds();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.pc", pc, 12'h200);
    chk("rst.valid", instr_valid, 1'b0);
    chk("rst.mem_rd", mem_rd, 1'b0);
    chk("rst.mem_addr", mem_addr, 12'h000);
    chk("rst.instr", instr_out, 16'h0000);
    chk("rst.err", stack_err, 1'b0);

    // First instruction arrives on the 5th edge; early ready is harmless.
    rd_log.delete();
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_rst.e%0d", e), instr_valid, (e == 5) ? 1'b1 : 1'b0);
    end
    instr_ready = 1'b0;
    chk("first.instr", instr_out, 16'h1234);
    chk("first.nreads", rd_log.size(), 2);
    if (rd_log.size() >= 2) begin
      chk("first.addr0", rd_log[0], 12'h200);
      chk("first.addr1", rd_log[1], 12'h201);
    end

    // HOLD stability with instr_ready low
    saved_pc = pc;
    saved_instr = instr_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold.c%0d", i), {instr_valid, mem_rd, pc, instr_out},
          {1'b1, 1'b0, saved_pc, saved_instr});
    end

    // Sequential consume, latency C+5, next reads from 0x202/0x203
    rd_log.delete();
    consume(0, 0, 0, 0, 12'h0);
    for (int e = 0; e <= 5; e++) begin
      if (e > 0) @(negedge clk);
      else @(negedge clk);
      chk($sformatf("lat_cons.e%0d", e), instr_valid, (e == 5) ? 1'b1 : 1'b0);
    end
    chk("seq.addr0", rd_log.size() > 0 ? rd_log[0] : 12'hxxx, 12'h202);
    chk("seq.addr1", rd_log.size() > 1 ? rd_log[1] : 12'hxxx, 12'h203);
    await_check("seq202", 0);

    // Call / return
    consume(0, 0, 0, 0, 12'h0);      await_check("seq204", 20);
    consume(0, 1, 0, 0, 12'h300);    await_check("call300", 20);
    consume(1, 0, 0, 0, 12'h0);      await_check("ret206", 20);

    // 16 nested calls, a 17th overflows, then one ret pops the 16th entry
    for (int i = 0; i < 16; i++) begin
      consume(0, 1, 0, 0, 12'($urandom));
      await_check($sformatf("nest%0d", i), 20);
    end
    consume(0, 1, 0, 0, 12'hABC);    await_check("overflow", 20);
    consume(1, 0, 0, 0, 12'h0);      await_check("ret_after_ovf", 20);

    // Underflow from reset; reset clears the sticky flag
    do_reset();
    chk("rst2.err", stack_err, 1'b0);
    await_check("rst2", 20);
    consume(1, 0, 0, 0, 12'h0);      await_check("underflow", 20);

    // Priority: ret wins over call/jump/skip and nothing is pushed
    do_reset();
    await_check("rst3", 20);
    consume(0, 0, 1, 0, 12'h24E);    await_check("jmp24e", 20);
    consume(0, 1, 0, 0, 12'h400);    await_check("call400", 20);
    consume(1, 1, 1, 1, 12'h777);    await_check("prio_ret", 20);
    consume(1, 0, 0, 0, 12'h0);      await_check("prio_nopush", 20);

    // PC wrap cases
    consume(0, 0, 1, 0, 12'hFFE);    await_check("jmpffe", 20);
    consume(0, 0, 0, 1, 12'h0);      await_check("skip_wrap", 20);
    consume(0, 0, 1, 0, 12'hFFE);    await_check("jmpffe2", 20);
    consume(0, 0, 0, 0, 12'h0);      await_check("seq_wrap", 20);
    consume(0, 0, 1, 0, 12'hFFF);    await_check("odd_fff", 20);

    // Reset during WAIT_LO abandons the fetch
    do_reset();
    await_check("rst4", 20);
    consume(0, 0, 0, 0, 12'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.valid", instr_valid, 1'b0);
    chk("midrst.pc", pc, 12'h200);
    repeat (2) @(negedge clk);
    model_reset();
    rd_log.delete();
    rst = 1'b0;
    await_check("refetch", 20);
    chk("refetch.addr0", rd_log.size() > 0 ? rd_log[0] : 12'hxxx, 12'h200);

    // Random latency, spurious mem_valid, stray commands outside HOLD
    max_extra = 3;
    spur_en = 1'b1;
    junk_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bit r, c, j, s;
      r = ($urandom_range(3, 0) == 0);
      c = ($urandom_range(3, 0) == 0);
      j = ($urandom_range(3, 0) == 0);
      s = ($urandom_range(3, 0) == 0);
      consume(r, c, j, s, 12'($urandom));
      await_check($sformatf("rnd%0d", i), 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
